vsim_portal_mux: RTL and testbench
==================================

VSIM_PORTAL_MUX -- requirements
Module: vsim_portal_mux

Interface
REQ-001 Parameters SHALL be:
- NUM_REQ, 4, request channel count (1..16)
- NUM_IND, 4, indication channel count (1..16)
- DATA_W, 32, beat/message width (>=32)
- GATHER_DEPTH, 8, indication burst buffer depth (power of 2, 1..256)
REQ-002 Ports SHALL be:
- CLK  in  1  sole clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- beat_in  in  DATA_W  request beat from simulation sink
- EN_beat_in  in  1  sink offers beat_in this cycle
- RDY_beat_in  out  1  block accepts beat_in this cycle
- req_v  out  DATA_W  request payload, shared by all channels
- EN_req  out  NUM_REQ  one-hot enqueue strobe
- RDY_req  in  NUM_REQ  per-channel request FIFO not full
- ind_first  in  NUM_IND*DATA_W  per-channel indication head word
- RDY_ind_first  in  NUM_IND  per-channel indication non-empty
- EN_ind_deq  out  NUM_IND  one-hot dequeue strobe
- beat_out  out  DATA_W  indication beat to simulation source
- RDY_beat_out  out  1  beat_out valid
- EN_beat_out  in  1  source consumes beat_out

Function
REQ-003 Transfers SHALL occur only when EN and RDY are both 1 in the same cycle; EN without RDY is ignored.
REQ-004 Request packet SHALL be one header beat (chan = beat_in[31:16], len = beat_in[15:0]) followed by len payload beats.
REQ-005 Request FSM SHALL have states R_HDR, R_PAY, R_DROP.
REQ-006 R_HDR: RDY_beat_in=1; on accepted header go R_PAY if chan<NUM_REQ, else R_DROP; len=0 stays in R_HDR.
REQ-007 R_PAY: RDY_beat_in = RDY_req[chan]; req_v = beat_in; EN_req[chan] = EN_beat_in & RDY_beat_in, combinational, zero latency.
REQ-008 R_DROP: RDY_beat_in=1; beats discarded, no EN_req.
REQ-009 A 16-bit remaining counter SHALL decrement per accepted payload beat; return to R_HDR after the beat that takes it to 0.
REQ-010 Indication FSM SHALL have states I_IDLE, I_GATHER, I_HDR, I_DRAIN.
REQ-011 I_IDLE: if any RDY_ind_first, grant g = first ready channel at or after rr_ptr (wrap-around), go I_GATHER.
REQ-012 I_GATHER: while RDY_ind_first[g] and count<GATHER_DEPTH, assert EN_ind_deq[g] and store ind_first[g] at count; else go I_HDR if count>=1, I_IDLE if count=0.
REQ-013 I_HDR: RDY_beat_out=1, beat_out = {g in [31:16], count in [15:0]}, upper bits zero; on consume go I_DRAIN.
REQ-014 I_DRAIN: RDY_beat_out=1, beat_out = buffered words in order; after last consumed, rr_ptr = (g+1) mod NUM_IND, count=0, go I_IDLE.
REQ-015 RDY_beat_out SHALL be 0 in I_IDLE and I_GATHER; beat_out stable while RDY_beat_out=1 and not consumed.
REQ-016 Request and indication paths SHALL be fully independent; simultaneous activity in the same cycle SHALL be supported.

Reset
REQ-017 RST asserted SHALL immediately force R_HDR, I_IDLE, rr_ptr=0, count=0, remaining=0, RDY_beat_out=0, EN_req=0, EN_ind_deq=0, beat_out=0.
REQ-018 Reset mid-packet SHALL abandon partial request packets and discard buffered indication words without emitting them.

Configuration
REQ-019 With VSIM_PORTAL_STATS_EN defined, outputs req_msg_count, ind_msg_count, drop_beat_count (32 bits each, saturating, reset 0) SHALL count accepted request headers, emitted indication headers, and beats consumed in R_DROP; without it these ports and counters SHALL be absent and behaviour otherwise identical.

Structure
REQ-020 Package vsim_portal_pkg SHALL hold header field positions/widths (HDR_CHAN_W=16, HDR_LEN_W=16) and both FSM state enums.
REQ-021 Gather storage SHALL be sub-module vsim_portal_gather_buf (GATHER_DEPTH x DATA_W, write/read pointers, count).

Verification
REQ-022 Header 0x0002_0003, payload A,B,C, RDY_req all 1 -> EN_req=4'b0100 with req_v A,B,C in 3 consecutive cycles; FSM back in R_HDR.
REQ-023 Header 0x0009_0002 (NUM_REQ=4) -> next 2 beats accepted, no EN_req; drop_beat_count=2 (stats build).
REQ-024 RDY_req[1]=0 mid-packet on channel 1 -> RDY_beat_in=0, no beats lost; resumes when RDY_req[1]=1.
REQ-025 Channels 0 and 2 each hold 3 words, EN_beat_out=1 -> output 0x0000_0003,w0..w2 then 0x0002_0003,w0..w2; rr_ptr=3.
REQ-026 Channel 1 holds 12 words, GATHER_DEPTH=8 -> header 0x0001_0008 + 8 words, then header 0x0001_0004 + 4 words.
REQ-027 RST asserted in I_DRAIN after 2 of 5 words -> RDY_beat_out=0 immediately, remaining words never emitted.

Source files
------------

// File: rtl/vsim_portal_pkg.sv
// vsim_portal_pkg: header field layout and FSM state types shared by the portal mux.
package vsim_portal_pkg;
  localparam int HDR_LEN_LSB = 0;
  localparam int HDR_LEN_W = 16;
  localparam int HDR_CHAN_LSB = HDR_LEN_LSB + HDR_LEN_W;
  localparam int HDR_CHAN_W = 16;
  typedef enum logic [1:0] {R_HDR, R_PAY, R_DROP} req_state_t;
  typedef enum logic [1:0] {I_IDLE, I_GATHER, I_HDR, I_DRAIN} ind_state_t;
endpackage

// File: rtl/vsim_portal_gather_buf.sv
// vsim_portal_gather_buf: burst buffer filled during gather and replayed in order during drain.
module vsim_portal_gather_buf #(
  parameter int DEPTH = 8,
  parameter int DATA_W = 32,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              clr,
  output logic [DATA_W-1:0] rd_data,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              last
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign full = count == CW'(DEPTH);
  assign last = CW'(rd_ptr) + 1'b1 == count;
  assign rd_data = mem[rd_ptr];
  always_ff @(posedge clk or posedge rst) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (wr_en && !full) begin
        wr_ptr <= wr_ptr + 1'b1;
        count <= count + 1'b1;
      end
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end
  always_ff @(posedge clk) if (wr_en && !full) mem[wr_ptr] <= wr_data;
endmodule

// File: rtl/vsim_portal_mux.sv
// vsim_portal_mux: demuxes request packets to channel FIFOs and gathers indication bursts round-robin.
// Define VSIM_PORTAL_STATS_EN to add saturating message/drop counters.
module vsim_portal_mux
  import vsim_portal_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int NUM_IND = 4,
  parameter int DATA_W = 32,
  parameter int GATHER_DEPTH = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_W-1:0]         beat_in,
  input  logic                      EN_beat_in,
  output logic                      RDY_beat_in,
  output logic [DATA_W-1:0]         req_v,
  output logic [NUM_REQ-1:0]        EN_req,
  input  logic [NUM_REQ-1:0]        RDY_req,
  input  logic [NUM_IND*DATA_W-1:0] ind_first,
  input  logic [NUM_IND-1:0]        RDY_ind_first,
  output logic [NUM_IND-1:0]        EN_ind_deq,
  output logic [DATA_W-1:0]         beat_out,
  output logic                      RDY_beat_out,
  input  logic                      EN_beat_out
`ifdef VSIM_PORTAL_STATS_EN
  ,
  output logic [31:0]               req_msg_count,
  output logic [31:0]               ind_msg_count,
  output logic [31:0]               drop_beat_count
`endif
);
  localparam int RCW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int IW = NUM_IND > 1 ? $clog2(NUM_IND) : 1;
  localparam int CW = $clog2(GATHER_DEPTH) + 1;
  req_state_t r_state, r_next;
  ind_state_t i_state, i_next;
  logic [RCW-1:0] chan, chan_next;
  logic [HDR_LEN_W-1:0] rem, rem_next;
  logic [HDR_LEN_W-1:0] hdr_len;
  logic [HDR_CHAN_W-1:0] hdr_chan;
  logic req_fire;
  logic [IW-1:0] g, g_next, rr_ptr, rr_next, grant;
  logic found, deq, rd_en, clr, full, last;
  logic [CW-1:0] count;
  logic [DATA_W-1:0] rd_data;
  assign hdr_len = beat_in[HDR_LEN_LSB +: HDR_LEN_W];
  assign hdr_chan = beat_in[HDR_CHAN_LSB +: HDR_CHAN_W];
  assign req_v = beat_in;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= R_HDR;
      chan <= '0;
      rem <= '0;
      i_state <= I_IDLE;
      g <= '0;
      rr_ptr <= '0;
    end else begin
      r_state <= r_next;
      chan <= chan_next;
      rem <= rem_next;
      i_state <= i_next;
      g <= g_next;
      rr_ptr <= rr_next;
    end
  end
  always_comb begin
    r_next = r_state;
    chan_next = chan;
    rem_next = rem;
    RDY_beat_in = r_state == R_PAY ? RDY_req[chan] : 1'b1;
    req_fire = EN_beat_in & RDY_beat_in;
    EN_req = (r_state == R_PAY && req_fire) ? NUM_REQ'(1) << chan : '0;
    if (req_fire && r_state == R_HDR) begin
      rem_next = hdr_len;
      chan_next = RCW'(hdr_chan);
      r_next = hdr_len == '0 ? R_HDR : hdr_chan < HDR_CHAN_W'(NUM_REQ) ? R_PAY : R_DROP;
    end else if (req_fire) begin
      rem_next = rem - 1'b1;
      r_next = rem == HDR_LEN_W'(1) ? R_HDR : r_state;
    end
  end
  // Round-robin pick: first ready channel at or after rr_ptr, wrapping.
  always_comb begin
    grant = rr_ptr;
    found = 1'b0;
    for (int i = 0; i < NUM_IND; i++) begin
      if (!found && RDY_ind_first[(int'(rr_ptr) + i) % NUM_IND]) begin
        found = 1'b1;
        grant = IW'((int'(rr_ptr) + i) % NUM_IND);
      end
    end
  end
  always_comb begin
    i_next = i_state;
    g_next = g;
    rr_next = rr_ptr;
    deq = 1'b0;
    rd_en = 1'b0;
    clr = 1'b0;
    RDY_beat_out = 1'b0;
    beat_out = '0;
    case (i_state)
      I_IDLE: if (found) begin
        g_next = grant;
        i_next = I_GATHER;
      end
      I_GATHER: if (RDY_ind_first[g] && !full) deq = 1'b1;
        else i_next = count != '0 ? I_HDR : I_IDLE;
      I_HDR: begin
        RDY_beat_out = 1'b1;
        beat_out = DATA_W'({HDR_CHAN_W'(g), HDR_LEN_W'(count)});
        if (EN_beat_out) i_next = I_DRAIN;
      end
      default: begin
        RDY_beat_out = 1'b1;
        beat_out = rd_data;
        rd_en = EN_beat_out;
        if (EN_beat_out && last) begin
          clr = 1'b1;
          rr_next = g == IW'(NUM_IND - 1) ? '0 : g + 1'b1;
          i_next = I_IDLE;
        end
      end
    endcase
    EN_ind_deq = NUM_IND'(deq) << g;
  end
  vsim_portal_gather_buf #(.DEPTH(GATHER_DEPTH), .DATA_W(DATA_W)) u_buf (
    .clk(CLK),
    .rst(RST),
    .wr_en(deq),
    .wr_data(ind_first[int'(g)*DATA_W +: DATA_W]),
    .rd_en(rd_en),
    .clr(clr),
    .rd_data(rd_data),
    .count(count),
    .full(full),
    .last(last)
  );
`ifdef VSIM_PORTAL_STATS_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      req_msg_count <= '0;
      ind_msg_count <= '0;
      drop_beat_count <= '0;
    end else begin
      if (req_fire && r_state == R_HDR && req_msg_count != '1) req_msg_count <= req_msg_count + 1'b1;
      if (EN_beat_out && i_state == I_HDR && ind_msg_count != '1) ind_msg_count <= ind_msg_count + 1'b1;
      if (req_fire && r_state == R_DROP && drop_beat_count != '1) drop_beat_count <= drop_beat_count + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_vsim_portal_mux.sv
// tb_vsim_portal_mux: directed scoreboard bench; a monitor pops expected request/indication beats.
module tb_vsim_portal_mux;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic [31:0] beat_in = '0;
  logic EN_beat_in = 1'b0;
  logic RDY_beat_in;
  logic [31:0] req_v;
  logic [3:0] EN_req;
  logic [3:0] RDY_req = 4'hF;
  logic [127:0] ind_first = '0;
  logic [3:0] RDY_ind_first = '0;
  logic [3:0] EN_ind_deq;
  logic [31:0] beat_out;
  logic RDY_beat_out;
  logic EN_beat_out = 1'b0;
`ifdef VSIM_PORTAL_STATS_EN
  logic [31:0] req_msg_count, ind_msg_count, drop_beat_count;
`endif
  always #5 CLK = ~CLK;

  vsim_portal_mux #(.NUM_REQ(4), .NUM_IND(4), .DATA_W(32), .GATHER_DEPTH(8)) dut (
    .CLK(CLK),
    .RST(RST),
    .beat_in(beat_in),
    .EN_beat_in(EN_beat_in),
    .RDY_beat_in(RDY_beat_in),
    .req_v(req_v),
    .EN_req(EN_req),
    .RDY_req(RDY_req),
    .ind_first(ind_first),
    .RDY_ind_first(RDY_ind_first),
    .EN_ind_deq(EN_ind_deq),
    .beat_out(beat_out),
    .RDY_beat_out(RDY_beat_out),
    .EN_beat_out(EN_beat_out)
`ifdef VSIM_PORTAL_STATS_EN
    ,
    .req_msg_count(req_msg_count),
    .ind_msg_count(ind_msg_count),
    .drop_beat_count(drop_beat_count)
`endif
  );

  logic [35:0] exp_req[$];
  logic [31:0] exp_ind[$];
  logic [31:0] chq [4][$];
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [31:0] v);
    int n;
    n = 0;
    beat_in = v;
    EN_beat_in = 1'b1;
    forever begin
      @(negedge CLK);
      if (RDY_beat_in) break;
      n++;
      if (n > 50) begin
        check("send_timeout", 32'(RDY_beat_in), 32'd1);
        break;
      end
    end
    step();
    EN_beat_in = 1'b0;
  endtask

  task automatic push_req(input logic [3:0] en, input logic [31:0] d);
    exp_req.push_back({en, d});
  endtask

  task automatic load(input int c, input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) chq[c].push_back(base + 32'(i));
  endtask

  task automatic push_burst(input logic [31:0] hdr, input int n, input logic [31:0] base);
    exp_ind.push_back(hdr);
    for (int i = 0; i < n; i++) exp_ind.push_back(base + 32'(i));
  endtask

  task automatic wait_ind_empty;
    int n;
    n = 0;
    while (exp_ind.size() != 0 && n < 400) begin
      step();
      n++;
    end
    check("ind_drain_timeout", 32'(exp_ind.size()), 32'd0);
  endtask

  // Indication channel FIFOs: head word visible while non-empty, popped on EN_ind_deq.
  initial begin : env
    logic [3:0] d;
    forever begin
      @(negedge CLK);
      d = EN_ind_deq;
      step();
      for (int c = 0; c < 4; c++) begin
        if (d[c] && chq[c].size() != 0) void'(chq[c].pop_front());
        RDY_ind_first[c] = chq[c].size() != 0;
        ind_first[c*32 +: 32] = chq[c].size() != 0 ? chq[c][0] : 32'h0;
      end
    end
  end

  initial begin : mon
    logic [35:0] e;
    forever begin
      @(negedge CLK);
      if (EN_req != 4'h0) begin
        if (exp_req.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL req_unexpected: got EN_req=%b req_v=%h expected no strobe", EN_req, req_v);
        end else begin
          e = exp_req.pop_front();
          check("req_en", {28'h0, EN_req}, {28'h0, e[35:32]});
          check("req_v", req_v, e[31:0]);
        end
      end
      if (RDY_beat_out && EN_beat_out) begin
        if (exp_ind.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL ind_unexpected: got beat_out=%h expected no beat", beat_out);
        end else check("beat_out", beat_out, exp_ind.pop_front());
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_rdy_out", 32'(RDY_beat_out), 32'd0);
    check("rst_beat_out", beat_out, 32'h0);
    check("rst_en_req", 32'(EN_req), 32'd0);
    check("rst_en_deq", 32'(EN_ind_deq), 32'd0);
    check("rst_rdy_in", 32'(RDY_beat_in), 32'd1);
    step();
    RST = 1'b0;
    // Three beats to channel 2 in consecutive cycles.
    push_req(4'b0100, 32'hAAAA_0001);
    push_req(4'b0100, 32'hBBBB_0002);
    push_req(4'b0100, 32'hCCCC_0003);
    send(32'h0002_0003);
    send(32'hAAAA_0001);
    send(32'hBBBB_0002);
    send(32'hCCCC_0003);
    RDY_req = 4'h0;
    @(negedge CLK);
    check("hdr_after_pay", 32'(RDY_beat_in), 32'd1);
    // Out-of-range channel drops payload regardless of RDY_req.
    send(32'h0009_0002);
    @(negedge CLK);
    check("drop_rdy", 32'(RDY_beat_in), 32'd1);
    send(32'hDEAD_0001);
    send(32'hDEAD_0002);
`ifdef VSIM_PORTAL_STATS_EN
    @(negedge CLK);
    check("drop_beat_count", drop_beat_count, 32'd2);
`endif
    RDY_req = 4'hF;
    // Zero-length header stays in header state.
    push_req(4'b0001, 32'h0D0D_0D0D);
    send(32'h0001_0000);
    send(32'h0000_0001);
    send(32'h0D0D_0D0D);
    // Highest valid channel versus first invalid one.
    push_req(4'b1000, 32'hEEEE_EEEE);
    send(32'h0003_0001);
    send(32'hEEEE_EEEE);
    send(32'h0004_0001);
    send(32'hFFFF_FFFF);
    // Backpressure on channel 1 mid-packet.
    push_req(4'b0010, 32'h1111_0000);
    push_req(4'b0010, 32'h1111_0001);
    push_req(4'b0010, 32'h1111_0002);
    send(32'h0001_0003);
    send(32'h1111_0000);
    RDY_req = 4'b1101;
    beat_in = 32'h1111_0001;
    EN_beat_in = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      check("stall_rdy_in", 32'(RDY_beat_in), 32'd0);
    end
    step();
    RDY_req = 4'hF;
    EN_beat_in = 1'b0;
    send(32'h1111_0001);
    send(32'h1111_0002);
    // Two channels ready: channel 0 then 2, leaving rr_ptr at 3.
    EN_beat_out = 1'b1;
    push_burst(32'h0000_0003, 3, 32'hA0A0_0000);
    push_burst(32'h0002_0003, 3, 32'hC0C0_0000);
    load(0, 3, 32'hA0A0_0000);
    load(2, 3, 32'hC0C0_0000);
    wait_ind_empty();
    push_burst(32'h0003_0001, 1, 32'hD3D3_0000);
    push_burst(32'h0001_0001, 1, 32'hD1D1_0000);
    load(1, 1, 32'hD1D1_0000);
    load(3, 1, 32'hD3D3_0000);
    wait_ind_empty();
    // Twelve words split into bursts of 8 and 4.
    push_burst(32'h0001_0008, 8, 32'h5151_0000);
    push_burst(32'h0001_0004, 4, 32'h5151_0008);
    load(1, 12, 32'h5151_0000);
    wait_ind_empty();
    // Reset during drain and during a request packet.
    EN_beat_out = 1'b0;
    load(3, 5, 32'h7373_0000);
    push_req(4'b0001, 32'h9999_0000);
    send(32'h0000_0005);
    send(32'h9999_0000);
    begin
      int n;
      n = 0;
      while (n < 100) begin
        @(negedge CLK);
        if (RDY_beat_out) break;
        n++;
      end
    end
    check("hdr_hold0", beat_out, 32'h0003_0005);
    @(negedge CLK);
    check("hdr_hold1", beat_out, 32'h0003_0005);
    push_burst(32'h0003_0005, 2, 32'h7373_0000);
    step();
    EN_beat_out = 1'b1;
    repeat (3) step();
    EN_beat_out = 1'b0;
    RST = 1'b1;
    #1;
    check("rst_drain_rdy", 32'(RDY_beat_out), 32'd0);
    check("rst_drain_beat", beat_out, 32'h0);
    check("rst_drain_deq", 32'(EN_ind_deq), 32'd0);
    repeat (2) step();
    RST = 1'b0;
    EN_beat_out = 1'b1;
    push_req(4'b0100, 32'h2222_2222);
    send(32'h0002_0001);
    send(32'h2222_2222);
    repeat (20) step();
    // rr_ptr back to 0: channel 1 wins over 3.
    push_burst(32'h0001_0001, 1, 32'hE1E1_0000);
    push_burst(32'h0003_0001, 1, 32'hE3E3_0000);
    load(1, 1, 32'hE1E1_0000);
    load(3, 1, 32'hE3E3_0000);
    wait_ind_empty();
    repeat (4) step();
    check("req_left", 32'(exp_req.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
